d_mem_arb: RTL and testbench

Two-requester arbiter in front of the single-port `d_mem` of `gpc_4t`. It shares the port between the core load/store path and the fabric (ring) access path. The core has priority; an aging counter guarantees fabric forward progress. The block also routes the 1-cycle-latency read data back to whichever requester issued the read, and squashes out-of-range accesses.

---
 rtl/gpc_4t_pkg.sv | 30 +++
 rtl/d_mem_arb_rsp.sv | 51 +++++
 rtl/d_mem_arb.sv | 110 +++++++++++
 tb/tb_d_mem_arb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpc_4t_pkg.sv
// Shared types and defaults for the gpc_4t data-memory path.
// The d_mem arbiter and its response stage both import this package.
package gpc_4t_pkg;

    typedef struct packed {
        logic        req;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  byteena;
        logic [31:0] wdata;
    } t_dmem_req;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_FAB  = 2'd2
    } t_dmem_owner;

    localparam int DMEM_STARVE_MAX = 4;
    localparam int DMEM_BYTES      = 4096;

    // A word access is legal only if its last byte lies inside the memory.
    // The sum is formed in 33 bits so that addresses near 2^32 cannot wrap.
    function automatic logic dmem_in_range(input logic [31:0] addr, input int unsigned mem_bytes);
        logic [32:0] last_byte;
        last_byte = {1'b0, addr} + 33'd3;
        return last_byte < 33'(mem_bytes);
    endfunction

endpackage

// File: rtl/d_mem_arb_rsp.sv
// Read-response stage: remembers who owns the read in flight and steers the
// registered d_mem output back to that requester one cycle after the grant.
module d_mem_arb_rsp
    import gpc_4t_pkg::*;
(
    input  logic        clock,
    input  logic        rst,
    input  logic        rd_issue,
    input  t_dmem_owner rd_owner,
    input  logic        rd_oor,
    input  logic [31:0] mem_q,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    output logic        fab_rvalid,
    output logic [31:0] fab_rdata
);

    t_dmem_owner rsp_own_reg, rsp_own_next;
    logic        rsp_oor_reg, rsp_oor_next;
    logic [31:0] rsp_data;

    always_ff @(posedge clock) begin
        if (rst) begin
            rsp_own_reg <= OWN_NONE;
            rsp_oor_reg <= 1'b0;
        end else begin
            rsp_own_reg <= rsp_own_next;
            rsp_oor_reg <= rsp_oor_next;
        end
    end

    always_comb begin
        rsp_own_next = OWN_NONE;
        rsp_oor_next = 1'b0;
        if (rd_issue) begin
            rsp_own_next = rd_owner;
            rsp_oor_next = rd_oor;
        end
    end

    // Responses are suppressed while rst is high so a read granted just
    // before reset never surfaces.
    always_comb begin
        rsp_data    = rsp_oor_reg ? 32'h0 : mem_q;
        core_rvalid = ~rst && (rsp_own_reg == OWN_CORE);
        fab_rvalid  = ~rst && (rsp_own_reg == OWN_FAB);
        core_rdata  = core_rvalid ? rsp_data : 32'h0;
        fab_rdata   = fab_rvalid  ? rsp_data : 32'h0;
    end

endmodule

// File: rtl/d_mem_arb.sv
// Core/fabric arbiter for the single-port d_mem: core priority with an aging
// counter for fabric forward progress, range check, and read-response routing.
module d_mem_arb
    import gpc_4t_pkg::*;
#(
    parameter int MEM_BYTES  = DMEM_BYTES,
    parameter int STARVE_MAX = DMEM_STARVE_MAX
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_wr,
    input  logic [31:0] core_addr,
    input  logic [3:0]  core_byteena,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    input  logic        fab_req,
    input  logic        fab_wr,
    input  logic [31:0] fab_addr,
    input  logic [3:0]  fab_byteena,
    input  logic [31:0] fab_wdata,
    output logic        fab_gnt,
    output logic        fab_rvalid,
    output logic [31:0] fab_rdata,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_byteena,
    output logic [31:0] mem_data,
    output logic        mem_rden,
    output logic        mem_wren,
    input  logic [31:0] mem_q,
    output logic        err_oor
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    t_dmem_req   core_bus, fab_bus, win_bus;
    logic [SC_W-1:0] starve_cnt_reg, starve_cnt_next;
    logic        fab_prio, any_gnt, win_in_range, rd_issue;
    t_dmem_owner rd_owner;

    assign core_bus = '{req: core_req, wr: core_wr, addr: core_addr,
                        byteena: core_byteena, wdata: core_wdata};
    assign fab_bus  = '{req: fab_req, wr: fab_wr, addr: fab_addr,
                        byteena: fab_byteena, wdata: fab_wdata};

    // A starved fabric overrides the core; otherwise the core always wins.
    always_comb begin
        fab_prio = fab_req && (starve_cnt_reg == SC_W'(STARVE_MAX));
        core_gnt = ~rst & core_req & ~fab_prio;
        fab_gnt  = ~rst & fab_req & (fab_prio | ~core_req);
        win_bus  = fab_gnt ? fab_bus : core_bus;
        any_gnt  = win_bus.req & (core_gnt | fab_gnt);
        win_in_range = dmem_in_range(win_bus.addr, MEM_BYTES);
    end

    always_comb begin
        mem_address = 32'h0;
        mem_byteena = 4'h0;
        mem_data    = 32'h0;
        mem_rden    = 1'b0;
        mem_wren    = 1'b0;
        err_oor     = 1'b0;
        if (any_gnt) begin
            mem_address = win_bus.addr;
            mem_byteena = win_bus.byteena;
            mem_data    = win_bus.wdata;
            mem_rden    = ~win_bus.wr & win_in_range;
            mem_wren    = win_bus.wr & win_in_range;
            err_oor     = ~win_in_range;
        end
    end

    // Out-of-range reads still get a (zeroed) response, so they are issued
    // to the response stage even though d_mem never sees them.
    assign rd_issue = any_gnt & ~win_bus.wr;
    assign rd_owner = fab_gnt ? OWN_FAB : OWN_CORE;

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (fab_gnt || !fab_req) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != SC_W'(STARVE_MAX)) begin
            starve_cnt_next = starve_cnt_reg + SC_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    d_mem_arb_rsp u_rsp (
        .clock       (clock),
        .rst         (rst),
        .rd_issue    (rd_issue),
        .rd_owner    (rd_owner),
        .rd_oor      (~win_in_range),
        .mem_q       (mem_q),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .fab_rvalid  (fab_rvalid),
        .fab_rdata   (fab_rdata)
    );

endmodule

// File: tb/tb_d_mem_arb.sv
// Directed bench for d_mem_arb with a behavioural 1-cycle-latency d_mem model.
module tb_d_mem_arb;

    logic        clock = 1'b0;
    logic        rst;
    logic        core_req, core_wr, fab_req, fab_wr;
    logic [31:0] core_addr, core_wdata, fab_addr, fab_wdata;
    logic [3:0]  core_byteena, fab_byteena;
    logic        core_gnt, core_rvalid, fab_gnt, fab_rvalid;
    logic [31:0] core_rdata, fab_rdata;
    logic [31:0] mem_address, mem_data, mem_q;
    logic [3:0]  mem_byteena;
    logic        mem_rden, mem_wren, err_oor;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] mem_arr [0:1023];

    always #5 clock = ~clock;

    d_mem_arb #(.MEM_BYTES(4096), .STARVE_MAX(4)) dut (
        .clock        (clock),
        .rst          (rst),
        .core_req     (core_req),
        .core_wr      (core_wr),
        .core_addr    (core_addr),
        .core_byteena (core_byteena),
        .core_wdata   (core_wdata),
        .core_gnt     (core_gnt),
        .core_rvalid  (core_rvalid),
        .core_rdata   (core_rdata),
        .fab_req      (fab_req),
        .fab_wr       (fab_wr),
        .fab_addr     (fab_addr),
        .fab_byteena  (fab_byteena),
        .fab_wdata    (fab_wdata),
        .fab_gnt      (fab_gnt),
        .fab_rvalid   (fab_rvalid),
        .fab_rdata    (fab_rdata),
        .mem_address  (mem_address),
        .mem_byteena  (mem_byteena),
        .mem_data     (mem_data),
        .mem_rden     (mem_rden),
        .mem_wren     (mem_wren),
        .mem_q        (mem_q),
        .err_oor      (err_oor)
    );

    // d_mem model: byte-enabled write, registered read.
    initial begin
        for (int i = 0; i < 1024; i++) mem_arr[i] = 32'h0;
        mem_q = 32'h0;
    end

    always @(posedge clock) begin
        if (mem_wren) begin
            for (int b = 0; b < 4; b++)
                if (mem_byteena[b]) mem_arr[mem_address[11:2]][8*b +: 8] <= mem_data[8*b +: 8];
        end
        if (mem_rden) mem_q <= mem_arr[mem_address[11:2]];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic core_set(input logic req, input logic wr, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata);
        core_req = req; core_wr = wr; core_addr = addr; core_byteena = be; core_wdata = wdata;
    endtask

    task automatic fab_set(input logic req, input logic wr, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
        fab_req = req; fab_wr = wr; fab_addr = addr; fab_byteena = be; fab_wdata = wdata;
    endtask

    task automatic idle();
        core_set(0, 0, 32'h0, 4'h0, 32'h0);
        fab_set(0, 0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        logic exp_fab, prev_core, prev_fab;
        rst = 1'b1;
        idle();
        cycle();
        cycle();

        // Requests during reset must not be granted.
        core_set(1, 0, 32'h10, 4'hF, 32'h0);
        #1;
        check_val("rst_core_gnt", 32'(core_gnt), 32'd0);
        check_val("rst_rden", 32'(mem_rden), 32'd0);
        check_val("rst_rvalid", 32'(core_rvalid), 32'd0);
        cycle();
        check_val("rst_starve", 32'(dut.starve_cnt_reg), 32'd0);
        rst = 1'b0;

        // Core write then read-back.
        core_set(1, 1, 32'h10, 4'hF, 32'hDEADBEEF);
        #1;
        check_val("wr_core_gnt", 32'(core_gnt), 32'd1);
        check_val("wr_wren", 32'(mem_wren), 32'd1);
        check_val("wr_addr", mem_address, 32'h10);
        check_val("wr_data", mem_data, 32'hDEADBEEF);
        cycle();
        core_set(1, 0, 32'h10, 4'hF, 32'h0);
        #1;
        check_val("rd_core_gnt", 32'(core_gnt), 32'd1);
        check_val("rd_rden", 32'(mem_rden), 32'd1);
        check_val("rd_rvalid_early", 32'(core_rvalid), 32'd0);
        cycle();
        idle();
        #1;
        check_val("rd_rvalid", 32'(core_rvalid), 32'd1);
        check_val("rd_rdata", core_rdata, 32'hDEADBEEF);
        check_val("rd_fab_rvalid", 32'(fab_rvalid), 32'd0);

        // Byte enables over zeroed memory.
        cycle();
        core_set(1, 1, 32'h40, 4'b0101, 32'h11223344);
        #1;
        check_val("be_byteena", 32'(mem_byteena), 32'h5);
        cycle();
        core_set(1, 0, 32'h40, 4'hF, 32'h0);
        cycle();
        idle();
        #1;
        check_val("be_rdata", core_rdata, 32'h00220044);

        // Preload for interleaved reads.
        cycle();
        core_set(1, 1, 32'h20, 4'hF, 32'h12345678);
        cycle();
        core_set(0, 0, 32'h0, 4'h0, 32'h0);
        fab_set(1, 1, 32'h24, 4'hF, 32'hCAFEF00D);
        #1;
        check_val("fab_wr_gnt", 32'(fab_gnt), 32'd1);
        cycle();
        fab_set(0, 0, 32'h0, 4'h0, 32'h0);
        core_set(1, 0, 32'h20, 4'hF, 32'h0);
        #1;
        check_val("il_core_gnt", 32'(core_gnt), 32'd1);
        cycle();
        core_set(0, 0, 32'h0, 4'h0, 32'h0);
        fab_set(1, 0, 32'h24, 4'hF, 32'h0);
        #1;
        check_val("il_fab_gnt", 32'(fab_gnt), 32'd1);
        check_val("il_core_rvalid", 32'(core_rvalid), 32'd1);
        check_val("il_core_rdata", core_rdata, 32'h12345678);
        check_val("il_fab_rvalid_early", 32'(fab_rvalid), 32'd0);
        cycle();
        idle();
        #1;
        check_val("il_fab_rvalid", 32'(fab_rvalid), 32'd1);
        check_val("il_fab_rdata", fab_rdata, 32'hCAFEF00D);
        check_val("il_core_rvalid_off", 32'(core_rvalid), 32'd0);
        check_val("il_core_rdata_off", core_rdata, 32'h0);

        // Contention: core 4 cycles, fabric on the 5th, repeating.
        prev_core = 1'b0;
        prev_fab  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            core_set(1, 0, 32'h10, 4'hF, 32'h0);
            fab_set(1, 0, 32'h24, 4'hF, 32'h0);
            #1;
            exp_fab = ((i % 5) == 4);
            check_val($sformatf("ct_fab_gnt_%0d", i), 32'(fab_gnt), 32'(exp_fab));
            check_val($sformatf("ct_core_gnt_%0d", i), 32'(core_gnt), 32'(!exp_fab));
            if (i > 0) begin
                check_val($sformatf("ct_core_rv_%0d", i), 32'(core_rvalid), 32'(prev_core));
                check_val($sformatf("ct_fab_rd_%0d", i), fab_rdata, prev_fab ? 32'hCAFEF00D : 32'h0);
            end
            prev_core = !exp_fab;
            prev_fab  = exp_fab;
        end
        cycle();
        idle();
        #1;
        check_val("ct_last_fab_rv", 32'(fab_rvalid), 32'd1);

        // Out-of-range fabric read; mem_q still holds 0xCAFEF00D.
        cycle();
        fab_set(1, 0, 32'd4094, 4'hF, 32'h0);
        #1;
        check_val("oor_gnt", 32'(fab_gnt), 32'd1);
        check_val("oor_err", 32'(err_oor), 32'd1);
        check_val("oor_rden", 32'(mem_rden), 32'd0);
        cycle();
        idle();
        #1;
        check_val("oor_rvalid", 32'(fab_rvalid), 32'd1);
        check_val("oor_rdata", fab_rdata, 32'h0);

        // Last legal word is in range.
        cycle();
        core_set(1, 0, 32'd4092, 4'hF, 32'h0);
        #1;
        check_val("edge_err", 32'(err_oor), 32'd0);
        check_val("edge_rden", 32'(mem_rden), 32'd1);

        // Reset right after a granted read drops the response.
        cycle();
        core_set(1, 0, 32'h10, 4'hF, 32'h0);
        fab_set(1, 0, 32'h24, 4'hF, 32'h0);
        #1;
        check_val("rm_core_gnt", 32'(core_gnt), 32'd1);
        cycle();
        rst = 1'b1;
        #1;
        check_val("rm_rvalid", 32'(core_rvalid), 32'd0);
        check_val("rm_core_gnt_rst", 32'(core_gnt), 32'd0);
        check_val("rm_fab_gnt_rst", 32'(fab_gnt), 32'd0);
        cycle();
        check_val("rm_starve", 32'(dut.starve_cnt_reg), 32'd0);
        check_val("rm_rvalid_after", 32'(core_rvalid), 32'd0);
        rst = 1'b0;
        fab_set(0, 0, 32'h0, 4'h0, 32'h0);
        core_set(1, 0, 32'h40, 4'hF, 32'h0);
        #1;
        check_val("rm_regnt", 32'(core_gnt), 32'd1);
        check_val("rm_regnt_rv", 32'(core_rvalid), 32'd0);
        cycle();
        idle();
        #1;
        check_val("rm_rdata", core_rdata, 32'h00220044);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
